// File: rtl/ltpi_pkg.sv
// Shared types and defaults for the LTPI Avalon-MM arbitration logic.
package ltpi_pkg;

    typedef enum logic [1:0] {
        ARB_IDLE    = 2'd0,
        ARB_ISSUE   = 2'd1,
        ARB_WAIT_RD = 2'd2
    } arb_state_e;

    localparam int unsigned DEFAULT_TIMEOUT_CYCLES = 32'd1024;
    localparam logic [31:0] DEFAULT_TIMEOUT_DATA   = 32'hDEAD_BEEF;

endpackage

// File: rtl/ltpi_rr_arbiter.sv
// Combinational round-robin selector: search starts just after last_grant and
// wraps, so the requester nearest after the previous winner takes priority.
module ltpi_rr_arbiter #(
    parameter int N = 2
) (
    input  logic [N-1:0]         req,
    input  logic [$clog2(N)-1:0] last_grant,
    output logic [N-1:0]         grant,
    output logic [$clog2(N)-1:0] grant_idx
);

    localparam int IW = $clog2(N);

    logic [IW-1:0] cand_s;
    logic          hit_s;

    // Scan from the farthest candidate to the nearest so the nearest active one wins.
    always_comb begin
        grant     = '0;
        grant_idx = '0;
        cand_s    = '0;
        hit_s     = 1'b0;
        for (int k = N - 1; k >= 0; k--) begin
            cand_s = IW'((int'(last_grant) + 1 + k) % N);
            if (req[cand_s]) begin
                grant_idx = cand_s;
                hit_s     = 1'b1;
            end else begin
                hit_s = hit_s;
            end
        end
        if (hit_s) begin
            grant[grant_idx] = 1'b1;
        end else begin
            grant = '0;
        end
    end

endmodule

// File: rtl/ltpi_avmm_arbiter.sv
// Round-robin share of one Avalon-MM target between NUM_REQ requesters, one
// transaction in flight, with a read-response timeout that never lets a requester hang.
module ltpi_avmm_arbiter
    import ltpi_pkg::*;
#(
    parameter int                    NUM_REQ        = 2,
    parameter int                    ADDR_WIDTH     = 32,
    parameter int                    DATA_WIDTH     = 32,
    parameter int                    TIMEOUT_CYCLES = DEFAULT_TIMEOUT_CYCLES,
    parameter logic [DATA_WIDTH-1:0] TIMEOUT_DATA   = DATA_WIDTH'(DEFAULT_TIMEOUT_DATA)
) (
    input  logic                              clk,
    input  logic                              reset_n,
    input  logic [NUM_REQ*ADDR_WIDTH-1:0]     req_address,
    input  logic [NUM_REQ-1:0]                req_read,
    input  logic [NUM_REQ-1:0]                req_write,
    input  logic [NUM_REQ*DATA_WIDTH-1:0]     req_writedata,
    input  logic [NUM_REQ*DATA_WIDTH/8-1:0]   req_byteenable,
    output logic [NUM_REQ-1:0]                req_waitrequest,
    output logic [DATA_WIDTH-1:0]             req_readdata,
    output logic [NUM_REQ-1:0]                req_readdatavalid,
    output logic [ADDR_WIDTH-1:0]             m_address,
    output logic                              m_read,
    output logic                              m_write,
    output logic [DATA_WIDTH-1:0]             m_writedata,
    output logic [DATA_WIDTH/8-1:0]           m_byteenable,
    input  logic                              m_waitrequest,
    input  logic [DATA_WIDTH-1:0]             m_readdata,
    input  logic                              m_readdatavalid,
    output logic [$clog2(NUM_REQ)-1:0]        grant_id,
    output logic                              busy,
    output logic                              timeout_pulse
);

    localparam int                BE_WIDTH  = DATA_WIDTH / 8;
    localparam int                IDX_WIDTH = $clog2(NUM_REQ);
    localparam int                CNT_WIDTH = $clog2(TIMEOUT_CYCLES);
    localparam logic [CNT_WIDTH-1:0] CNT_LAST = CNT_WIDTH'(TIMEOUT_CYCLES - 1);
    localparam logic [IDX_WIDTH-1:0] PTR_RESET = IDX_WIDTH'(NUM_REQ - 1);

    arb_state_e            state_r;
    logic [IDX_WIDTH-1:0]  ptr_r;
    logic [IDX_WIDTH-1:0]  grant_id_r;
    logic [CNT_WIDTH-1:0]  cnt_r;
    logic                  to_valid_r;
    logic                  timeout_pulse_r;
    logic                  busy_r;
    logic [ADDR_WIDTH-1:0] m_address_r;
    logic                  m_read_r;
    logic                  m_write_r;
    logic [DATA_WIDTH-1:0] m_writedata_r;
    logic [BE_WIDTH-1:0]   m_byteenable_r;

    logic [NUM_REQ-1:0]    active_s;
    logic [NUM_REQ-1:0]    arb_grant_s;
    logic [IDX_WIDTH-1:0]  arb_idx_s;
    logic [ADDR_WIDTH-1:0] sel_address_s;
    logic [DATA_WIDTH-1:0] sel_writedata_s;
    logic [BE_WIDTH-1:0]   sel_byteenable_s;
    logic                  sel_read_s;
    logic                  sel_write_s;

    assign active_s = req_read | req_write;

    ltpi_rr_arbiter #(
        .N (NUM_REQ)
    ) u_rr (
        .req        (active_s),
        .last_grant (ptr_r),
        .grant      (arb_grant_s),
        .grant_idx  (arb_idx_s)
    );

    // Pick the winning requester's command fields.
    always_comb begin
        sel_address_s    = '0;
        sel_writedata_s  = '0;
        sel_byteenable_s = '0;
        sel_read_s       = 1'b0;
        sel_write_s      = 1'b0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (arb_grant_s[i]) begin
                sel_address_s    = req_address[i*ADDR_WIDTH +: ADDR_WIDTH];
                sel_writedata_s  = req_writedata[i*DATA_WIDTH +: DATA_WIDTH];
                sel_byteenable_s = req_byteenable[i*BE_WIDTH +: BE_WIDTH];
                sel_read_s       = req_read[i];
                sel_write_s      = req_write[i];
            end else begin
                sel_read_s = sel_read_s;
            end
        end
    end

    // Arbitration FSM, command registers and read-timeout counter.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_r         <= ARB_IDLE;
            ptr_r           <= PTR_RESET;
            grant_id_r      <= '0;
            cnt_r           <= '0;
            to_valid_r      <= 1'b0;
            timeout_pulse_r <= 1'b0;
            busy_r          <= 1'b0;
            m_address_r     <= '0;
            m_read_r        <= 1'b0;
            m_write_r       <= 1'b0;
            m_writedata_r   <= '0;
            m_byteenable_r  <= '0;
        end else begin
            to_valid_r      <= 1'b0;
            timeout_pulse_r <= 1'b0;
            case (state_r)
                ARB_IDLE: begin
                    if (|arb_grant_s) begin
                        m_address_r    <= sel_address_s;
                        m_writedata_r  <= sel_writedata_s;
                        m_byteenable_r <= sel_byteenable_s;
                        // A simultaneous read+write is a protocol error; the write wins.
                        m_write_r      <= sel_write_s;
                        m_read_r       <= sel_read_s & ~sel_write_s;
                        grant_id_r     <= arb_idx_s;
                        ptr_r          <= arb_idx_s;
                        busy_r         <= 1'b1;
                        state_r        <= ARB_ISSUE;
                    end
                end
                ARB_ISSUE: begin
                    if (!m_waitrequest) begin
                        m_read_r  <= 1'b0;
                        m_write_r <= 1'b0;
                        if (m_write_r) begin
                            busy_r  <= 1'b0;
                            state_r <= ARB_IDLE;
                        end else begin
                            cnt_r   <= '0;
                            state_r <= ARB_WAIT_RD;
                        end
                    end
                end
                ARB_WAIT_RD: begin
                    cnt_r <= cnt_r + CNT_WIDTH'(1);
                    if (m_readdatavalid) begin
                        busy_r  <= 1'b0;
                        state_r <= ARB_IDLE;
                    end else if (cnt_r == CNT_LAST) begin
                        to_valid_r      <= 1'b1;
                        timeout_pulse_r <= 1'b1;
                        busy_r          <= 1'b0;
                        state_r         <= ARB_IDLE;
                    end
                end
                default: begin
                    m_read_r  <= 1'b0;
                    m_write_r <= 1'b0;
                    busy_r    <= 1'b0;
                    state_r   <= ARB_IDLE;
                end
            endcase
        end
    end

    // Only the grantee ever sees the target's waitrequest, and only while issuing.
    always_comb begin
        req_waitrequest = '1;
        if (state_r == ARB_ISSUE) begin
            req_waitrequest[grant_id_r] = m_waitrequest;
        end else begin
            req_waitrequest = '1;
        end
    end

    // Response mux: live target data in WAIT_RD, or the registered timeout reply.
    always_comb begin
        req_readdatavalid = '0;
        req_readdata      = m_readdata;
        if (to_valid_r) begin
            req_readdatavalid[grant_id_r] = 1'b1;
            req_readdata                  = TIMEOUT_DATA;
        end else if ((state_r == ARB_WAIT_RD) && m_readdatavalid) begin
            req_readdatavalid[grant_id_r] = 1'b1;
        end else begin
            req_readdatavalid = '0;
        end
    end

    assign m_address     = m_address_r;
    assign m_read        = m_read_r;
    assign m_write       = m_write_r;
    assign m_writedata   = m_writedata_r;
    assign m_byteenable  = m_byteenable_r;
    assign grant_id      = grant_id_r;
    assign busy          = busy_r;
    assign timeout_pulse = timeout_pulse_r;

endmodule

// File: tb/tb_ltpi_avmm_arbiter.sv
// Self-checking bench: a vector table for arbitration plus hand sequences for
// wait states, response forwarding, timeout, late responses and mid-transaction reset.
module tb_ltpi_avmm_arbiter;

    localparam int NR = 2;
    localparam int AW = 32;
    localparam int DW = 32;
    localparam int TO = 16;

    logic              clk = 1'b0;
    logic              reset_n = 1'b0;
    logic [NR*AW-1:0]  req_address = '0;
    logic [NR-1:0]     req_read = '0;
    logic [NR-1:0]     req_write = '0;
    logic [NR*DW-1:0]  req_writedata = '0;
    logic [NR*DW/8-1:0] req_byteenable = '0;
    logic [NR-1:0]     req_waitrequest;
    logic [DW-1:0]     req_readdata;
    logic [NR-1:0]     req_readdatavalid;
    logic [AW-1:0]     m_address;
    logic              m_read;
    logic              m_write;
    logic [DW-1:0]     m_writedata;
    logic [DW/8-1:0]   m_byteenable;
    logic              m_waitrequest = 1'b0;
    logic [DW-1:0]     m_readdata = '0;
    logic              m_readdatavalid = 1'b0;
    logic [0:0]        grant_id;
    logic              busy;
    logic              timeout_pulse;

    always #5 clk = ~clk;

    ltpi_avmm_arbiter #(
        .NUM_REQ        (NR),
        .ADDR_WIDTH     (AW),
        .DATA_WIDTH     (DW),
        .TIMEOUT_CYCLES (TO),
        .TIMEOUT_DATA   (32'hDEAD_BEEF)
    ) dut (
        .clk               (clk),
        .reset_n           (reset_n),
        .req_address       (req_address),
        .req_read          (req_read),
        .req_write         (req_write),
        .req_writedata     (req_writedata),
        .req_byteenable    (req_byteenable),
        .req_waitrequest   (req_waitrequest),
        .req_readdata      (req_readdata),
        .req_readdatavalid (req_readdatavalid),
        .m_address         (m_address),
        .m_read            (m_read),
        .m_write           (m_write),
        .m_writedata       (m_writedata),
        .m_byteenable      (m_byteenable),
        .m_waitrequest     (m_waitrequest),
        .m_readdata        (m_readdata),
        .m_readdatavalid   (m_readdatavalid),
        .grant_id          (grant_id),
        .busy              (busy),
        .timeout_pulse     (timeout_pulse)
    );

    typedef struct {
        int            idx;
        logic [DW-1:0] data;
    } sb_t;

    typedef struct {
        logic [1:0] rd;
        logic [1:0] wr;
        int         gid;
        logic       mrd;
        logic       mwr;
    } vec_t;

    sb_t  sb_q[$];
    sb_t  mon_e;
    vec_t vecs[9];
    int   checks = 0;
    int   errors = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Scoreboard: every forwarded response must match the oldest expected one.
    always @(negedge clk) begin
        if (reset_n && (req_readdatavalid != 2'b00)) begin
            if (sb_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_rdv: got valid %b data %h expected no response",
                         req_readdatavalid, req_readdata);
            end else begin
                mon_e = sb_q.pop_front();
                chk("rdv_vec", 64'(req_readdatavalid), 64'(2'b01 << mon_e.idx));
                chk("rdv_data", 64'(req_readdata), 64'(mon_e.data));
            end
        end
    end

    initial begin
        logic [DW-1:0] d;
        logic [AW-1:0] exp_addr [2];
        logic [3:0]    exp_be [2];

        vecs[0] = '{2'b11, 2'b00, 0, 1'b1, 1'b0};
        vecs[1] = '{2'b11, 2'b00, 1, 1'b1, 1'b0};
        vecs[2] = '{2'b11, 2'b00, 0, 1'b1, 1'b0};
        vecs[3] = '{2'b11, 2'b00, 1, 1'b1, 1'b0};
        vecs[4] = '{2'b10, 2'b00, 1, 1'b1, 1'b0};
        vecs[5] = '{2'b00, 2'b01, 0, 1'b0, 1'b1};
        vecs[6] = '{2'b01, 2'b01, 0, 1'b0, 1'b1};
        vecs[7] = '{2'b00, 2'b11, 1, 1'b0, 1'b1};
        vecs[8] = '{2'b01, 2'b10, 0, 1'b1, 1'b0};
        exp_addr[0] = 32'h0000_1000;
        exp_addr[1] = 32'h0000_2000;
        exp_be[0]   = 4'h3;
        exp_be[1]   = 4'hC;

        // Reset values
        repeat (2) @(posedge clk);
        #3 reset_n = 1'b1;
        #1;
        chk("rst_m_read", 64'(m_read), 64'(1'b0));
        chk("rst_m_write", 64'(m_write), 64'(1'b0));
        chk("rst_m_address", 64'(m_address), 64'(32'h0));
        chk("rst_m_writedata", 64'(m_writedata), 64'(32'h0));
        chk("rst_m_be", 64'(m_byteenable), 64'(4'h0));
        chk("rst_grant_id", 64'(grant_id), 64'(1'b0));
        chk("rst_busy", 64'(busy), 64'(1'b0));
        chk("rst_timeout", 64'(timeout_pulse), 64'(1'b0));
        chk("rst_waitreq", 64'(req_waitrequest), 64'(2'b11));
        chk("rst_rdv", 64'(req_readdatavalid), 64'(2'b00));

        // Write with three target wait states
        req_address[31:0]  = 32'h0000_0200;
        req_writedata[31:0] = 32'h1234_5678;
        req_byteenable[3:0] = 4'hF;
        req_write     = 2'b01;
        m_waitrequest = 1'b1;
        for (int c = 1; c <= 4; c++) begin
            tick();
            chk("wr_m_write", 64'(m_write), 64'(1'b1));
            chk("wr_m_read", 64'(m_read), 64'(1'b0));
            chk("wr_addr", 64'(m_address), 64'(32'h0000_0200));
            chk("wr_data", 64'(m_writedata), 64'(32'h1234_5678));
            chk("wr_be", 64'(m_byteenable), 64'(4'hF));
            chk("wr_gid", 64'(grant_id), 64'(1'b0));
            if (c < 4) begin
                chk("wr_waitreq_hold", 64'(req_waitrequest), 64'(2'b11));
            end else begin
                m_waitrequest = 1'b0;
                #1;
                chk("wr_waitreq_drop", 64'(req_waitrequest), 64'(2'b10));
                req_write = 2'b00;
            end
        end
        tick();
        chk("wr_done_m_write", 64'(m_write), 64'(1'b0));
        chk("wr_done_busy", 64'(busy), 64'(1'b0));

        // Requester 1 read, response three cycles after acceptance
        req_address[63:32] = 32'h0000_0100;
        req_read = 2'b10;
        tick();
        chk("rd1_gid", 64'(grant_id), 64'(1'b1));
        chk("rd1_m_read", 64'(m_read), 64'(1'b1));
        chk("rd1_addr", 64'(m_address), 64'(32'h0000_0100));
        req_read = 2'b00;
        tick();
        chk("rd1_m_read_drop", 64'(m_read), 64'(1'b0));
        tick();
        tick();
        m_readdata      = 32'hA5A5_0001;
        m_readdatavalid = 1'b1;
        sb_q.push_back('{1, 32'hA5A5_0001});
        tick();
        m_readdatavalid = 1'b0;
        chk("rd1_busy", 64'(busy), 64'(1'b0));

        // Arbitration vector table
        req_address    = {32'h0000_2000, 32'h0000_1000};
        req_writedata  = {32'hC0DE_0001, 32'hC0DE_0000};
        req_byteenable = {4'hC, 4'h3};
        foreach (vecs[i]) begin
            req_read  = vecs[i].rd;
            req_write = vecs[i].wr;
            tick();
            chk($sformatf("v%0d_gid", i), 64'(grant_id), 64'(vecs[i].gid));
            chk($sformatf("v%0d_m_read", i), 64'(m_read), 64'(vecs[i].mrd));
            chk($sformatf("v%0d_m_write", i), 64'(m_write), 64'(vecs[i].mwr));
            chk($sformatf("v%0d_addr", i), 64'(m_address), 64'(exp_addr[vecs[i].gid]));
            chk($sformatf("v%0d_waitreq", i), 64'(req_waitrequest),
                64'((vecs[i].gid == 0) ? 2'b10 : 2'b01));
            if (vecs[i].mwr) begin
                chk($sformatf("v%0d_wdata", i), 64'(m_writedata),
                    64'(32'hC0DE_0000 + 32'(vecs[i].gid)));
                chk($sformatf("v%0d_be", i), 64'(m_byteenable), 64'(exp_be[vecs[i].gid]));
            end
            req_read  = 2'b00;
            req_write = 2'b00;
            tick();
            if (vecs[i].mrd) begin
                d = $urandom;
                m_readdata      = d;
                m_readdatavalid = 1'b1;
                sb_q.push_back('{vecs[i].gid, d});
                tick();
                m_readdatavalid = 1'b0;
            end
            chk($sformatf("v%0d_idle", i), 64'(busy), 64'(1'b0));
        end

        // Read timeout followed by a late response that must be dropped
        req_address[63:32] = 32'h0000_0300;
        req_read = 2'b10;
        tick();
        chk("to_gid", 64'(grant_id), 64'(1'b1));
        chk("to_m_read", 64'(m_read), 64'(1'b1));
        req_read = 2'b00;
        tick();
        sb_q.push_back('{1, 32'hDEAD_BEEF});
        for (int k = 1; k <= TO + 1; k++) begin
            tick();
            if (k == TO) begin
                chk("to_pulse_hit", 64'(timeout_pulse), 64'(1'b1));
                chk("to_busy", 64'(busy), 64'(1'b0));
            end else begin
                chk($sformatf("to_pulse_k%0d", k), 64'(timeout_pulse), 64'(1'b0));
            end
        end
        repeat (4) tick();
        m_readdata      = 32'h1111_1111;
        m_readdatavalid = 1'b1;
        tick();
        m_readdatavalid = 1'b0;
        chk("late_busy", 64'(busy), 64'(1'b0));

        // Reset asserted while waiting for read data
        req_address[31:0] = 32'h0000_0400;
        req_read = 2'b01;
        tick();
        chk("rr_gid_pre", 64'(grant_id), 64'(1'b0));
        req_read = 2'b00;
        tick();
        tick();
        tick();
        chk("rr_busy_pre", 64'(busy), 64'(1'b1));
        #2 reset_n = 1'b0;
        #1;
        chk("rr_busy", 64'(busy), 64'(1'b0));
        chk("rr_m_addr", 64'(m_address), 64'(32'h0));
        chk("rr_waitreq", 64'(req_waitrequest), 64'(2'b11));
        chk("rr_rdv", 64'(req_readdatavalid), 64'(2'b00));
        tick();
        #2 reset_n = 1'b1;
        m_readdata      = 32'h2222_2222;
        m_readdatavalid = 1'b1;
        tick();
        m_readdatavalid = 1'b0;
        req_address = {32'h0000_0600, 32'h0000_0500};
        req_read    = 2'b11;
        tick();
        chk("rr_first_gid", 64'(grant_id), 64'(1'b0));
        chk("rr_first_addr", 64'(m_address), 64'(32'h0000_0500));
        req_read = 2'b00;
        tick();
        m_readdata      = 32'h3333_4444;
        m_readdatavalid = 1'b1;
        sb_q.push_back('{0, 32'h3333_4444});
        tick();
        m_readdatavalid = 1'b0;
        tick();

        chk("sb_empty", 64'(sb_q.size()), 64'(0));
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
